// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the write-back arbiter: default sizes and requester indices.
package regfile_wb_arbiter_pkg;

  localparam logic CONST_ZERO = 1'b0;

  localparam int unsigned DEFAULT_WIDTH   = 32;
  localparam int unsigned DEFAULT_REGBITS = 3;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LSU = 1;
  localparam int unsigned REQ_MDU = 2;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Stateless round-robin pick: first requester at or after ptr (mod N) wins.
module rr_arbiter #(
  parameter int unsigned N  = 3,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    logic          found;
    int unsigned   k;
    logic [IW-1:0] kk;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    kk      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k  = (32'(ptr) + i) % N;
      kk = IW'(k);
      if (!found && req[kk]) begin
        found   = 1'b1;
        gnt[kk] = 1'b1;
        gnt_idx = kk;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter with pending-write scoreboard and hazard detection.
// Optional WB_BYPASS_EN adds byp1_o/byp2_o and exempts committing sources from hazard_o.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned REGBITS = DEFAULT_REGBITS,
  parameter int unsigned NREQ    = REQ_MDU + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*REGBITS-1:0] req_wa_i,
  input  logic [NREQ*WIDTH-1:0]   req_wd_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic                    rsv_valid_i,
  input  logic [REGBITS-1:0]      rsv_wa_i,
  input  logic [REGBITS-1:0]      ra1_i,
  input  logic [REGBITS-1:0]      ra2_i,
  output logic                    hazard_o,
  output logic [2**REGBITS-1:0]   busy_o,
  output logic                    regwrite_o,
  output logic [REGBITS-1:0]      wa_o,
`ifdef WB_BYPASS_EN
  output logic                    byp1_o,
  output logic                    byp2_o,
`endif
  output logic [WIDTH-1:0]        wd_o
);

  localparam int unsigned NREG = 2 ** REGBITS;
  localparam int unsigned IW   = $clog2(NREQ);

  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;
  logic [REGBITS-1:0] gnt_wa;
  logic [WIDTH-1:0]   gnt_wd;
  logic               regwrite_q;
  logic [REGBITS-1:0] wa_q;
  logic [WIDTH-1:0]   wd_q;
  logic [NREG-1:0]    busy_q, busy_d;
  logic               src1_haz, src2_haz, waw_haz;

  rr_arbiter #(
    .N(NREQ)
  ) u_rr_arbiter (
    .req     (req_valid_i),
    .ptr     (ptr_q),
    .gnt     (req_ready_o),
    .gnt_idx (gnt_idx)
  );

  assign gnt_any = |req_ready_o;
  assign gnt_wa  = req_wa_i[gnt_idx*REGBITS +: REGBITS];
  assign gnt_wd  = req_wd_i[gnt_idx*WIDTH +: WIDTH];
  assign ptr_d   = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);

  // Set after clear so a same-cycle reservation survives the commit.
  always_comb begin
    busy_d = busy_q;
    if (regwrite_q) busy_d[wa_q] = 1'b0;
    if (rsv_valid_i && (rsv_wa_i != '0)) busy_d[rsv_wa_i] = 1'b1;
    busy_d[0] = CONST_ZERO;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
      regwrite_q <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      busy_q     <= '0;
    end else begin
      busy_q <= busy_d;
      if (gnt_any) begin
        ptr_q      <= ptr_d;
        wa_q       <= gnt_wa;
        wd_q       <= gnt_wd;
        regwrite_q <= (gnt_wa != '0);
      end else begin
        regwrite_q <= 1'b0;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign byp1_o   = regwrite_q && (wa_q == ra1_i) && (ra1_i != '0);
  assign byp2_o   = regwrite_q && (wa_q == ra2_i) && (ra2_i != '0);
  assign src1_haz = busy_q[ra1_i] && (ra1_i != '0) && !byp1_o;
  assign src2_haz = busy_q[ra2_i] && (ra2_i != '0) && !byp2_o;
`else
  assign src1_haz = busy_q[ra1_i] && (ra1_i != '0);
  assign src2_haz = busy_q[ra2_i] && (ra2_i != '0);
`endif
  assign waw_haz  = rsv_valid_i && busy_q[rsv_wa_i];
  assign hazard_o = src1_haz || src2_haz || waw_haz;

  assign regwrite_o = regwrite_q;
  assign wa_o       = wa_q;
  assign wd_o       = wd_q;
  assign busy_o     = busy_q;

endmodule
